// File: rtl/split_slave_pkg.sv
// split_slave_pkg: bus encodings, region decode values and FSM enums
// shared by the split_slave top and its memory.
package split_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    // haddr[7:6]; any value with bit 7 set is unmapped
    localparam logic [1:0] REGION_FAST = 2'b00;
    localparam logic [1:0] REGION_SLOW = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP1,
        ST_RESP2
    } state_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_PEND,
        SP_REL
    } split_e;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_DONE,
        ACT_WAIT,
        ACT_RESP
    } act_e;

    function automatic logic is_xfer(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/split_slave_mem.sv
// split_slave_mem: 16x32 word store, one synchronous write port and
// one asynchronous read port; contents are not reset.
module split_slave_mem
    import split_slave_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem_q [16];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/split_slave.sv
// split_slave: bus slave with fast, wait-state and unmapped regions.
// Define SPLIT_SLAVE_SPLIT_EN to answer unlocked slow accesses with SPLIT/RETRY.
module split_slave
    import split_slave_pkg::*;
#(
    parameter int WAIT_CYC  = 2,
    parameter int SPLIT_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic [1:0]  hmaster,
    input  logic        hmastlock,
    output logic        hready,
    output logic [1:0]  hresp,
    output logic [1:0]  hsplit,
    output logic [31:0] hrdata
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYC - 1);
    localparam act_e SLOW_ACT = (WAIT_CYC == 0) ? ACT_DONE : ACT_WAIT;

    state_e      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [1:0]  resp_q, resp_d;
    logic        dph_q, dph_d;
    logic        dwr_q, dwr_d;
    logic [3:0]  didx_q, didx_d;
    logic        accept;
    act_e        act;
    logic [1:0]  act_resp;
    logic        mem_we;
    logic [31:0] mem_rdata;

`ifdef SPLIT_SLAVE_SPLIT_EN
    localparam logic [7:0] SPLIT_LAST = 8'(SPLIT_LAT - 1);

    split_e      sp_st_q, sp_st_d;
    logic        sp_mst_q, sp_mst_d;
    logic [31:0] sp_addr_q, sp_addr_d;
    logic [7:0]  sp_cnt_q, sp_cnt_d;
    logic [1:0]  hsplit_q, hsplit_d;
    logic        sp_new;
    logic        sp_clr;
`else
    logic        lint_unused;
    assign lint_unused = ^{hmaster, hmastlock, haddr[31:8], haddr[1:0]};
`endif

    assign hready = (state_q == ST_IDLE) || (state_q == ST_RESP2);
    assign accept = hsel && hready && is_xfer(htrans);

    always_comb begin
        act      = ACT_NONE;
        act_resp = HRESP_OKAY;
`ifdef SPLIT_SLAVE_SPLIT_EN
        sp_new   = 1'b0;
        sp_clr   = 1'b0;
`endif
        if (accept) begin
            unique case (haddr[7:6])
                REGION_FAST: act = ACT_DONE;
                REGION_SLOW: begin
`ifdef SPLIT_SLAVE_SPLIT_EN
                    if (hmastlock || (hmaster > 2'd1)) begin
                        act = SLOW_ACT;
                    end else if (sp_st_q == SP_NONE) begin
                        act      = ACT_RESP;
                        act_resp = HRESP_SPLIT;
                        sp_new   = 1'b1;
                    end else if ((sp_st_q == SP_REL) &&
                                 (hmaster[0] == sp_mst_q) &&
                                 (haddr == sp_addr_q)) begin
                        act    = ACT_DONE;
                        sp_clr = 1'b1;
                    end else begin
                        act      = ACT_RESP;
                        act_resp = HRESP_RETRY;
                    end
`else
                    act = SLOW_ACT;
`endif
                end
                default: begin
                    act      = ACT_RESP;
                    act_resp = HRESP_ERROR;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        resp_d  = resp_q;
        dph_d   = dph_q;
        dwr_d   = dwr_q;
        didx_d  = didx_q;
        unique case (state_q)
            ST_IDLE: dph_d = 1'b0;
            ST_WAIT: begin
                wcnt_d = wcnt_q + 8'd1;
                if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end
            end
            ST_RESP1: state_d = ST_RESP2;
            ST_RESP2: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // a data phase completing this cycle may overlap the next address phase
        if (accept) begin
            dwr_d  = hwrite;
            didx_d = haddr[5:2];
            dph_d  = (act == ACT_DONE) || (act == ACT_WAIT);
            unique case (act)
                ACT_WAIT: begin
                    state_d = ST_WAIT;
                    wcnt_d  = '0;
                end
                ACT_RESP: begin
                    state_d = ST_RESP1;
                    resp_d  = act_resp;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        hresp  = HRESP_OKAY;
        hrdata = '0;
        mem_we = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (dph_q) begin
                    mem_we = dwr_q;
                    if (!dwr_q) begin
                        hrdata = mem_rdata;
                    end
                end
            end
            ST_RESP1, ST_RESP2: hresp = resp_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            resp_q  <= HRESP_OKAY;
            dph_q   <= 1'b0;
            dwr_q   <= 1'b0;
            didx_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            resp_q  <= resp_d;
            dph_q   <= dph_d;
            dwr_q   <= dwr_d;
            didx_q  <= didx_d;
        end
    end

`ifdef SPLIT_SLAVE_SPLIT_EN
    // release timer runs on its own, regardless of the transfer FSM
    always_comb begin
        sp_st_d   = sp_st_q;
        sp_mst_d  = sp_mst_q;
        sp_addr_d = sp_addr_q;
        sp_cnt_d  = sp_cnt_q;
        hsplit_d  = 2'b00;
        if (sp_st_q == SP_PEND) begin
            sp_cnt_d = sp_cnt_q + 8'd1;
            if (sp_cnt_q == SPLIT_LAST) begin
                sp_st_d  = SP_REL;
                sp_cnt_d = '0;
                hsplit_d = sp_mst_q ? 2'b10 : 2'b01;
            end
        end
        if (sp_new) begin
            sp_st_d   = SP_PEND;
            sp_mst_d  = hmaster[0];
            sp_addr_d = haddr;
            sp_cnt_d  = '0;
        end
        if (sp_clr) begin
            sp_st_d = SP_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_st_q   <= SP_NONE;
            sp_mst_q  <= 1'b0;
            sp_addr_q <= '0;
            sp_cnt_q  <= '0;
            hsplit_q  <= 2'b00;
        end else begin
            sp_st_q   <= sp_st_d;
            sp_mst_q  <= sp_mst_d;
            sp_addr_q <= sp_addr_d;
            sp_cnt_q  <= sp_cnt_d;
            hsplit_q  <= hsplit_d;
        end
    end

    assign hsplit = hsplit_q;
`else
    assign hsplit = 2'b00;
`endif

    split_slave_mem u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (didx_q),
        .wdata (hwdata),
        .raddr (didx_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_split_slave.sv
// tb_split_slave: directed vectors for split_slave, one cycle at a time,
// outputs sampled 1ns after the rising edge.
module tb_split_slave;

    logic        clk;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [1:0]  hmaster;
    logic        hmastlock;
    logic        hready;
    logic [1:0]  hresp;
    logic [1:0]  hsplit;
    logic [31:0] hrdata;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef SPLIT_SLAVE_SPLIT_EN
    localparam logic [1:0] SLOW_RESP = 2'b11;
`else
    localparam logic [1:0] SLOW_RESP = 2'b00;
`endif

    split_slave #(
        .WAIT_CYC  (2),
        .SPLIT_LAT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hmaster   (hmaster),
        .hmastlock (hmastlock),
        .hready    (hready),
        .hresp     (hresp),
        .hsplit    (hsplit),
        .hrdata    (hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_bus(input string tag, input logic rdy,
                              input logic [1:0] resp, input logic [1:0] spl,
                              input logic [31:0] data);
        check({tag, ".hready"}, 32'(hready), 32'(rdy));
        check({tag, ".hresp"},  32'(hresp),  32'(resp));
        check({tag, ".hsplit"}, 32'(hsplit), 32'(spl));
        check({tag, ".hrdata"}, hrdata, data);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one address phase, return in the first data-phase cycle
    task automatic start(input logic [31:0] a, input logic w,
                         input logic [1:0] m, input logic l);
        hsel      = 1'b1;
        htrans    = 2'b10;
        haddr     = a;
        hwrite    = w;
        hmaster   = m;
        hmastlock = l;
        step();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    initial begin
        rst       = 1'b0;
        hsel      = 1'b0;
        haddr     = '0;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        hwdata    = '0;
        hmaster   = 2'd0;
        hmastlock = 1'b0;
        step();
        step();
        expect_bus("reset", 1'b1, 2'b00, 2'b00, 32'h0);
        rst = 1'b1;
        step();

        // fast write then read back
        start(32'h04, 1'b1, 2'd0, 1'b0);
        hwdata = 32'hDEADBEEF;
        expect_bus("fast.wr", 1'b1, 2'b00, 2'b00, 32'h0);
        start(32'h04, 1'b0, 2'd0, 1'b0);
        hwdata = 32'h0;
        expect_bus("fast.rd", 1'b1, 2'b00, 2'b00, 32'hDEADBEEF);
        step();

        // not selected / BUSY: no transfer taken
        hsel   = 1'b1;
        htrans = 2'b01;
        haddr  = 32'h80;
        step();
        expect_bus("busy", 1'b1, 2'b00, 2'b00, 32'h0);
        hsel   = 1'b0;
        htrans = 2'b10;
        step();
        expect_bus("nosel", 1'b1, 2'b00, 2'b00, 32'h0);
        htrans = 2'b00;
        step();

        // unmapped read and write
        start(32'h80, 1'b0, 2'd0, 1'b0);
        expect_bus("err.rd1", 1'b0, 2'b01, 2'b00, 32'h0);
        step();
        expect_bus("err.rd2", 1'b1, 2'b01, 2'b00, 32'h0);
        step();
        start(32'h84, 1'b1, 2'd0, 1'b0);
        hwdata = 32'h12345678;
        expect_bus("err.wr1", 1'b0, 2'b01, 2'b00, 32'h0);
        step();
        expect_bus("err.wr2", 1'b1, 2'b01, 2'b00, 32'h0);
        step();
        start(32'h04, 1'b0, 2'd0, 1'b0);
        expect_bus("err.nowr", 1'b1, 2'b00, 2'b00, 32'hDEADBEEF);
        step();

        // locked slow read by master 1
        start(32'h00, 1'b1, 2'd0, 1'b0);
        hwdata = 32'hA5A50001;
        step();
        start(32'h40, 1'b0, 2'd1, 1'b1);
        expect_bus("lock.w1", 1'b0, 2'b00, 2'b00, 32'h0);
        step();
        expect_bus("lock.w2", 1'b0, 2'b00, 2'b00, 32'h0);
        step();
        expect_bus("lock.done", 1'b1, 2'b00, 2'b00, 32'hA5A50001);
        step();

        // slow write by master 2 always takes wait states
        start(32'h44, 1'b1, 2'd2, 1'b0);
        hwdata = 32'h5A5A0044;
        expect_bus("m2.w1", 1'b0, 2'b00, 2'b00, 32'h0);
        step();
        expect_bus("m2.w2", 1'b0, 2'b00, 2'b00, 32'h0);
        step();
        expect_bus("m2.done", 1'b1, 2'b00, 2'b00, 32'h0);
        step();
        start(32'h04, 1'b0, 2'd0, 1'b0);
        expect_bus("m2.rdbk", 1'b1, 2'b00, 2'b00, 32'h5A5A0044);
        step();

        start(32'h08, 1'b1, 2'd0, 1'b0);
        hwdata = 32'hCAFE0002;
        step();

`ifdef SPLIT_SLAVE_SPLIT_EN
        start(32'h48, 1'b0, 2'd0, 1'b0);
        expect_bus("spl.c1", 1'b0, 2'b11, 2'b00, 32'h0);
        step();
        expect_bus("spl.c2", 1'b1, 2'b11, 2'b00, 32'h0);
        step();
        expect_bus("spl.c3", 1'b1, 2'b00, 2'b00, 32'h0);
        start(32'h4C, 1'b0, 2'd1, 1'b0);
        expect_bus("rty.c1", 1'b0, 2'b10, 2'b00, 32'h0);
        step();
        expect_bus("rty.c2", 1'b1, 2'b10, 2'b01, 32'h0);
        step();
        expect_bus("rel.off", 1'b1, 2'b00, 2'b00, 32'h0);
        start(32'h48, 1'b0, 2'd0, 1'b0);
        expect_bus("spl.hit", 1'b1, 2'b00, 2'b00, 32'hCAFE0002);
        step();
`else
        start(32'h48, 1'b0, 2'd0, 1'b0);
        expect_bus("slow.w1", 1'b0, 2'b00, 2'b00, 32'h0);
        step();
        expect_bus("slow.w2", 1'b0, 2'b00, 2'b00, 32'h0);
        step();
        expect_bus("slow.done", 1'b1, 2'b00, 2'b00, 32'hCAFE0002);
        step();
`endif

        // reset in the middle of a slow access
        start(32'h48, 1'b0, 2'd0, 1'b0);
        expect_bus("rst.pre", 1'b0, SLOW_RESP, 2'b00, 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        expect_bus("rst.in", 1'b1, 2'b00, 2'b00, 32'h0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("rst.hsplit%0d", i), 32'(hsplit), 32'h0);
        end
        start(32'h08, 1'b0, 2'd0, 1'b0);
        expect_bus("rst.mem", 1'b1, 2'b00, 2'b00, 32'hCAFE0002);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
